// File: rtl/wdt_kick_master_if.sv
// Wishbone classic bus bundle between the watchdog kick master and the watchdog slave.
interface wdt_kick_master_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] wb_dat_o;
    logic [WIDTH-1:0] wb_dat_i;
    logic             wb_we_o;
    logic             wb_stb_o;
    logic             wb_cyc_o;
    logic             wb_ack_i;

    modport master (
        output wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wdt_kick_master.sv
// Hardware keep-alive agent for the watchdog: periodically writes RELOAD to the
// watchdog counter, reads it back, checks the value is plausible, and counts
// watchdog interrupt edges.
module wdt_kick_master #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      KICK_PERIOD  = 1000,
    parameter logic [WIDTH-1:0] RELOAD       = WIDTH'(32'h1000),
    parameter int unsigned      CHECK_WINDOW = 16,
    parameter int unsigned      ACK_TIMEOUT  = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wdt_kick_master_if.master  wb,
    input  logic               wdt_int_i,
    input  logic               enable_i,
    input  logic               kick_req_i,
    output logic               busy_o,
    output logic               err_o,
    output logic [7:0]         int_cnt_o,
    output logic [WIDTH-1:0]   last_val_o
);

    localparam int PW = $clog2(KICK_PERIOD);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WRITE, S_GAP_W, S_READ, S_GAP_R, S_ERROR
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    period_q;
    logic [TW-1:0]    tmo_q;
    logic             gap_q;
    logic             stb_q;
    logic             we_q;
    logic [WIDTH-1:0] dat_q;
    logic             busy_q;
    logic             err_q;
    logic [WIDTH-1:0] last_val_q;
    logic             int_sync_q;
    logic             int_prev_q;
    logic [7:0]       int_cnt_q;
    logic [7:0]       int_cnt_d;
    logic             int_rise;
    logic             readback_ok;

    // Interrupt edge detect on the registered level, and the saturating edge count.
    always_comb begin
        int_rise  = int_sync_q & ~int_prev_q;
        int_cnt_d = int_cnt_q;
        if (int_rise && (int_cnt_q != 8'hFF)) begin
            int_cnt_d = int_cnt_q + 8'd1;
        end
    end

    // Readback is plausible only if it has not run past RELOAD and has counted down by at most CHECK_WINDOW.
    always_comb begin
        readback_ok = (last_val_q <= RELOAD) &&
                      ((RELOAD - last_val_q) <= WIDTH'(CHECK_WINDOW));
    end

    // Kick sequencer: one FSM owning every registered bus and status output.
    // NOTE: every register here clears on the async reset, so a reset mid-transfer drops cyc/stb at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            period_q   <= '0;
            tmo_q      <= '0;
            gap_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            last_val_q <= '0;
            int_sync_q <= 1'b0;
            int_prev_q <= 1'b0;
            int_cnt_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            int_sync_q <= wdt_int_i;
            int_prev_q <= int_sync_q;
            int_cnt_q  <= int_cnt_d;

            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q <= S_WRITE;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        dat_q   <= RELOAD;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if ((period_q == '0) || kick_req_i || int_rise) begin
                        state_q <= S_WRITE;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        dat_q   <= RELOAD;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        period_q <= period_q - 1'b1;
                    end
                end
                S_WRITE, S_READ: begin
                    if (wb.wb_ack_i) begin
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        gap_q <= 1'b1;
                        if (state_q == S_READ) begin
                            last_val_q <= wb.wb_dat_i;
                            state_q    <= S_GAP_R;
                        end else begin
                            state_q <= S_GAP_W;
                        end
                    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERROR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_GAP_W: begin
                    if (!gap_q) begin
                        state_q <= S_READ;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                        tmo_q   <= '0;
                    end else begin
                        gap_q <= 1'b0;
                    end
                end
                S_GAP_R: begin
                    if (!gap_q) begin
                        busy_q <= 1'b0;
                        if (!readback_ok) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERROR;
                        end else if (!enable_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q  <= S_WAIT;
                            period_q <= PW'(KICK_PERIOD - 1);
                        end
                    end else begin
                        gap_q <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (!enable_i) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o = stb_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_dat_o = dat_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign int_cnt_o   = int_cnt_q;
    assign last_val_o  = last_val_q;

endmodule

// File: tb/tb_wdt_kick_master.sv
// Directed bench for wdt_kick_master with a watchdog slave model and a
// scoreboard of expected bus transactions checked on each ack.
module tb_wdt_kick_master;

    localparam logic [31:0] RELOAD = 32'h1000;

    typedef struct {
        logic        we;
        logic [31:0] dat;
    } xact_t;

    logic        clk;
    logic        rst;
    logic        wdt_int;
    logic        enable;
    logic        kick_req;
    logic        busy;
    logic        err;
    logic [7:0]  int_cnt;
    logic [31:0] last_val;
    logic [31:0] rd_data;
    logic        ack_mode;
    int          age;
    int          checks;
    int          failures;
    xact_t       exp_q[$];
    xact_t       sb_x;

    wdt_kick_master_if #(.WIDTH(32)) bus ();

    wdt_kick_master #(
        .WIDTH(32), .KICK_PERIOD(20), .RELOAD(RELOAD), .CHECK_WINDOW(16), .ACK_TIMEOUT(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus), .wdt_int_i(wdt_int), .enable_i(enable),
        .kick_req_i(kick_req), .busy_o(busy), .err_o(err), .int_cnt_o(int_cnt), .last_val_o(last_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.wb_dat_i = rd_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watchdog slave: acks one cycle after stb rises and scores the transaction.
    always @(negedge clk) begin
        if (rst || (bus.wb_stb_o !== 1'b1)) begin
            age = 0;
            bus.wb_ack_i = 1'b0;
        end else begin
            age++;
            bus.wb_ack_i = 1'b0;
            if (ack_mode && (age == 2)) begin
                bus.wb_ack_i = 1'b1;
                check("sb_cyc_eq_stb", {31'd0, bus.wb_cyc_o}, {31'd0, bus.wb_stb_o});
                check("sb_not_empty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    sb_x = exp_q.pop_front();
                    check("sb_we", {31'd0, bus.wb_we_o}, {31'd0, sb_x.we});
                    if (sb_x.we) check("sb_wdat", bus.wb_dat_o, sb_x.dat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input int budget, output int n);
        n = 0;
        while ((bus.wb_stb_o !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        check("stb_rise", {31'd0, bus.wb_stb_o}, 32'd1);
    endtask

    task automatic wait_stb_low(input int budget);
        int n;
        n = 0;
        while ((bus.wb_stb_o !== 1'b0) && (n < budget)) begin
            tick();
            n++;
        end
        check("stb_fall", {31'd0, bus.wb_stb_o}, 32'd0);
    endtask

    // Completes a kick sequence whose write strobe is already up.
    task automatic bus_seq(input logic [31:0] rd, input logic exp_err);
        int n;
        rd_data = rd;
        exp_q.push_back('{we: 1'b1, dat: RELOAD});
        exp_q.push_back('{we: 1'b0, dat: 32'd0});
        check("wr_we", {31'd0, bus.wb_we_o}, 32'd1);
        check("wr_dat", bus.wb_dat_o, RELOAD);
        wait_stb_low(30);
        wait_stb(10, n);
        check("rw_gap", 32'(n), 32'd2);
        check("rd_we", {31'd0, bus.wb_we_o}, 32'd0);
        wait_stb_low(30);
        n = 0;
        while (busy && (n < 10)) begin
            tick();
            n++;
        end
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("last_val", last_val, rd);
        check("err_after_seq", {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stb"}, {31'd0, bus.wb_stb_o}, 32'd0);
        check({tag, "_cyc"}, {31'd0, bus.wb_cyc_o}, 32'd0);
        check({tag, "_we"}, {31'd0, bus.wb_we_o}, 32'd0);
        check({tag, "_dat"}, bus.wb_dat_o, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_int_cnt"}, {24'd0, int_cnt}, 32'd0);
        check({tag, "_last_val"}, last_val, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int exp_cnt;
        checks = 0; failures = 0;
        rst = 1'b0; wdt_int = 1'b0; enable = 1'b0; kick_req = 1'b0;
        rd_data = 32'd0; ack_mode = 1'b1; bus.wb_ack_i = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // First kick from IDLE is immediate.
        enable = 1'b1;
        wait_stb(5, n);
        check("first_kick_latency", 32'(n), 32'd1);
        bus_seq(32'h0000_0FF8, 1'b0);

        // Five periodic sequences, each 20 cycles after the previous GAP_R.
        for (int i = 0; i < 5; i++) begin
            wait_stb(40, n);
            check("period_gap", 32'(n), 32'd20);
            case (i)
                0: bus_seq(RELOAD, 1'b0);
                1: bus_seq(32'h0000_0FFF, 1'b0);
                2: bus_seq(32'h0000_0FF0, 1'b0);
                default: bus_seq(32'h0000_0FFA, 1'b0);
            endcase
        end

        // kick_req_i on the third WAIT cycle kicks on the next edge; period reloads afterwards.
        tick();
        tick();
        kick_req = 1'b1;
        tick();
        kick_req = 1'b0;
        check("kick_req_stb", {31'd0, bus.wb_stb_o}, 32'd1);
        check("kick_req_we", {31'd0, bus.wb_we_o}, 32'd1);
        bus_seq(32'h0000_0FFC, 1'b0);

        // Interrupt edge in WAIT forces an early kick.
        repeat (4) tick();
        wdt_int = 1'b1;
        wait_stb(5, n);
        wdt_int = 1'b0;
        check("int_cnt_one", {24'd0, int_cnt}, 32'd1);
        bus_seq(32'h0000_0FFE, 1'b0);

        // Check window boundaries.
        wait_stb(40, n);
        check("period_reload", 32'(n), 32'd20);
        bus_seq(RELOAD - 32'd16, 1'b0);
        wait_stb(40, n);
        bus_seq(RELOAD - 32'd17, 1'b1);
        repeat (5) tick();
        check("err_sticky", {31'd0, err}, 32'd1);
        check("err_bus_idle", {31'd0, bus.wb_stb_o}, 32'd0);
        enable = 1'b0;
        tick();
        check("err_clear", {31'd0, err}, 32'd0);
        repeat (3) tick();
        check("idle_no_stb", {31'd0, bus.wb_stb_o}, 32'd0);

        // Stopped watchdog reads all-ones.
        enable = 1'b1;
        wait_stb(5, n);
        bus_seq(32'hFFFF_FFFF, 1'b1);
        enable = 1'b0;
        tick();
        check("err_clear2", {31'd0, err}, 32'd0);

        // Slave never acks: stb held for ACK_TIMEOUT cycles, then error.
        ack_mode = 1'b0;
        enable = 1'b1;
        wait_stb(5, n);
        n = 0;
        while ((bus.wb_stb_o === 1'b1) && (n < 40)) begin
            tick();
            n++;
        end
        check("tmo_stb_cycles", 32'(n), 32'd16);
        check("tmo_err", {31'd0, err}, 32'd1);
        repeat (3) tick();
        check("tmo_err_sticky", {31'd0, err}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        enable = 1'b0;
        tick();
        check("tmo_err_clear", {31'd0, err}, 32'd0);
        ack_mode = 1'b1;

        // 300 interrupt edges saturate the counter.
        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            wdt_int = 1'b1;
            tick();
            wdt_int = 1'b0;
            tick();
            if (exp_cnt < 255) exp_cnt++;
            if (i == 49) check("int_cnt_mid", {24'd0, int_cnt}, 32'(exp_cnt));
        end
        repeat (3) tick();
        check("int_cnt_sat", {24'd0, int_cnt}, 32'd255);
        check("int_idle_no_kick", {31'd0, bus.wb_stb_o}, 32'd0);

        // Reset asserted mid-READ clears every output within the cycle.
        enable = 1'b1;
        wait_stb(5, n);
        exp_q.push_back('{we: 1'b1, dat: RELOAD});
        wait_stb_low(30);
        wait_stb(10, n);
        check("mid_read_we", {31'd0, bus.wb_we_o}, 32'd0);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_read_reset");
        enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
